mult_share_arbiter: RTL and testbench

//  Shares one combinational W x W array multiplier (module main: x,y -> o) among NREQ requesters.

---
 rtl/mult_share_arbiter_if.sv | 31 +++
 rtl/mult_share_arbiter.sv | 159 +++++++++++++++
 tb/tb_mult_share_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mult_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// mult_share_arbiter_if : requester and result channels of the shared-multiplier arbiter
// Rev 1.0
// ============================================================================
interface mult_share_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [W*NREQ-1:0] req_x;
  logic [W*NREQ-1:0] req_y;
  logic              res_valid;
  logic              res_ready;
  logic [2*W-1:0]    res_data;
  logic [IDW-1:0]    res_id;

  modport master (
    output req_valid, req_x, req_y, res_ready,
    input  req_ready, res_valid, res_data, res_id
  );

  modport slave (
    input  req_valid, req_x, req_y, res_ready,
    output req_ready, res_valid, res_data, res_id
  );
endinterface
`default_nettype wire

// File: rtl/mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// mult_share_arbiter : round-robin sharing of one W x W multiplier among NREQ clients.
// Optional product checker enabled by defining MULT_SHARE_SELFCHECK_EN (adds chk_err_o).
// Rev 1.0
// ============================================================================
module mult_share_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 4
) (
  input  wire logic           clk,
  input  wire logic           rst,
  mult_share_arbiter_if.slave bus,
  output logic [W-1:0]        mul_x_o,
  output logic [W-1:0]        mul_y_o,
  input  wire logic [2*W-1:0] mul_o_i,
  output logic                busy_o
`ifdef MULT_SHARE_SELFCHECK_EN
  ,
  output logic                chk_err_o
`endif
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     mul_x_q, mul_x_d;
  logic [W-1:0]     mul_y_q, mul_y_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic             res_valid_q, res_valid_d;
  logic [2*W-1:0]   res_data_q, res_data_d;
  logic [IDW-1:0]   res_id_q, res_id_d;

  logic [W-1:0]     w_req_x [NREQ];
  logic [W-1:0]     w_req_y [NREQ];
  logic             w_found;
  logic [IDW-1:0]   w_winner;
  logic             w_accept_ok;
  logic             w_grant;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign w_req_x[i] = bus.req_x[i*W +: W];
    assign w_req_y[i] = bus.req_y[i*W +: W];
  end

  // First valid requester strictly after the last winner, wrapping modulo NREQ.
  always_comb begin
    int idx;
    w_found  = 1'b0;
    w_winner = '0;
    idx      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NREQ;
      if (!w_found && bus.req_valid[idx]) begin
        w_found  = 1'b1;
        w_winner = IDW'(idx);
      end
    end
  end

  // Reset also suppresses grants so nothing is accepted while rst is high.
  assign w_accept_ok   = !rst && ((state_q == S_IDLE) || ((state_q == S_HOLD) && bus.res_ready));
  assign w_grant       = w_accept_ok && w_found;
  assign bus.req_ready = w_grant ? (NREQ'(1) << w_winner) : '0;

  always_comb begin
    state_d     = state_q;
    mul_x_d     = mul_x_q;
    mul_y_d     = mul_y_q;
    id_d        = id_q;
    rr_ptr_d    = rr_ptr_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;

    case (state_q)
      S_IDLE: begin
        if (w_grant) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        res_data_d  = mul_o_i;
        res_id_d    = id_q;
        res_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = w_grant ? S_ISSUE : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (w_grant) begin
      mul_x_d  = w_req_x[w_winner];
      mul_y_d  = w_req_y[w_winner];
      id_d     = w_winner;
      rr_ptr_d = w_winner;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mul_x_q     <= '0;
      mul_y_q     <= '0;
      id_q        <= '0;
      rr_ptr_q    <= IDW'(NREQ - 1);
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      mul_x_q     <= mul_x_d;
      mul_y_q     <= mul_y_d;
      id_q        <= id_d;
      rr_ptr_q    <= rr_ptr_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
    end
  end

`ifdef MULT_SHARE_SELFCHECK_EN
  logic [2*W-1:0] w_prod;
  logic           chk_err_q, chk_err_d;

  assign w_prod = (2*W)'(mul_x_q) * (2*W)'(mul_y_q);

  // Sticky: once the shared multiplier disagrees, only reset clears the flag.
  always_comb begin
    chk_err_d = chk_err_q;
    if ((state_q == S_ISSUE) && (mul_o_i != w_prod)) chk_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) chk_err_q <= 1'b0;
    else     chk_err_q <= chk_err_d;
  end

  assign chk_err_o = chk_err_q;
`endif

  assign mul_x_o       = mul_x_q;
  assign mul_y_o       = mul_y_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;
  assign busy_o        = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mult_share_arbiter : directed self-checking bench for mult_share_arbiter
// Rev 1.0
// ============================================================================
module tb_mult_share_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] mul_x;
  logic [3:0] mul_y;
  logic [7:0] mul_o;
  logic       busy;
  logic       force_zero = 1'b0;
`ifdef MULT_SHARE_SELFCHECK_EN
  logic       chk_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mult_share_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  mult_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .mul_x_o (mul_x),
    .mul_y_o (mul_y),
    .mul_o_i (mul_o),
    .busy_o  (busy)
`ifdef MULT_SHARE_SELFCHECK_EN
    ,
    .chk_err_o (chk_err)
`endif
  );

  // Stand-in for the shared combinational multiplier, with a fault switch.
  assign mul_o = force_zero ? 8'h00 : ({4'h0, mul_x} * {4'h0, mul_y});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [3:0] x, input logic [3:0] y);
    bus.req_x[i*W +: W] = x;
    bus.req_y[i*W +: W] = y;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.req_valid = 4'hF;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.res_ready = 1'b1;

    // T1 reset with every requester valid
    tick;
    tick;
    check("rst_req_ready", 32'(bus.req_ready), 32'h0);
    check("rst_res_valid", 32'(bus.res_valid), 32'h0);
    check("rst_busy",      32'(busy),          32'h0);
    check("rst_mul_x",     32'(mul_x),         32'h0);
    check("rst_mul_y",     32'(mul_y),         32'h0);
    rst = 1'b0;

    // T3 round-robin from reset: ids 0,1,2,3,0 with products 3,6,9,12,3
    for (int i = 0; i < 4; i++) set_op(i, 4'(i + 1), 4'd3);
    bus.req_valid = 4'hF;
    #1;
    check("rr_first_grant", 32'(bus.req_ready), 32'h1);
    tick;
    for (int k = 0; k < 5; k++) begin
      check("rr_issue_gap", 32'(bus.res_valid), 32'h0);
      tick;
      check("rr_res_valid", 32'(bus.res_valid), 32'h1);
      check("rr_res_id",    32'(bus.res_id),    32'(k % 4));
      check("rr_res_data",  32'(bus.res_data),  32'(((k % 4) + 1) * 3));
      if (k == 4) bus.req_valid = 4'h0;
      #1;
      check("rr_next_grant", 32'(bus.req_ready), (k == 4) ? 32'h0 : 32'(1 << ((k + 1) % 4)));
      tick;
    end

    // T2 single op from requester 2: F*F = E1
    set_op(2, 4'hF, 4'hF);
    bus.req_valid = 4'b0100;
    #1;
    check("single_grant", 32'(bus.req_ready), 32'h4);
    tick;
    bus.req_valid = 4'h0;
    #1;
    check("single_ready_drop", 32'(bus.req_ready), 32'h0);
    check("single_busy",       32'(busy),          32'h1);
    check("single_mul_x",      32'(mul_x),         32'hF);
    check("single_no_early",   32'(bus.res_valid), 32'h0);
    tick;
    check("single_res_valid", 32'(bus.res_valid), 32'h1);
    check("single_res_data",  32'(bus.res_data),  32'hE1);
    check("single_res_id",    32'(bus.res_id),    32'h2);
    tick;
    check("single_done_valid", 32'(bus.res_valid), 32'h0);
    check("single_done_busy",  32'(busy),          32'h0);

    // T4 backpressure on A*7 = 46 from requester 3, requester 0 waiting
    set_op(3, 4'hA, 4'h7);
    set_op(0, 4'h2, 4'h2);
    bus.req_valid = 4'b1000;
    bus.res_ready = 1'b0;
    #1;
    check("bp_grant", 32'(bus.req_ready), 32'h8);
    tick;
    bus.req_valid = 4'b1001;
    tick;
    for (int c = 0; c < 5; c++) begin
      check("bp_res_valid", 32'(bus.res_valid), 32'h1);
      check("bp_res_data",  32'(bus.res_data),  32'h46);
      check("bp_res_id",    32'(bus.res_id),    32'h3);
      check("bp_req_ready", 32'(bus.req_ready), 32'h0);
      tick;
    end
    bus.res_ready = 1'b1;
    #1;
    check("bp_same_cycle_grant", 32'(bus.req_ready), 32'h1);
    tick;
    check("bp_issue_valid", 32'(bus.res_valid), 32'h0);
    bus.req_valid = 4'h0;
    tick;
    check("bp_next_data", 32'(bus.res_data), 32'h04);
    check("bp_next_id",   32'(bus.res_id),   32'h0);
    tick;

    // T5 reset during ISSUE drops the operation and restarts round-robin at 0
    set_op(2, 4'h5, 4'h5);
    bus.req_valid = 4'b0100;
    tick;
    bus.req_valid = 4'h0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("midrst_res_valid", 32'(bus.res_valid), 32'h0);
    check("midrst_busy",      32'(busy),          32'h0);
    check("midrst_mul_x",     32'(mul_x),         32'h0);
    for (int c = 0; c < 3; c++) begin
      tick;
      check("midrst_no_result", 32'(bus.res_valid), 32'h0);
    end
    bus.req_valid = 4'hF;
    #1;
    check("midrst_rr_restart", 32'(bus.req_ready), 32'h1);
    bus.req_valid = 4'h0;
    #1;

`ifdef MULT_SHARE_SELFCHECK_EN
    // T6 faulty product sets the sticky flag; real multiplier never does
    check("chk_reset", 32'(chk_err), 32'h0);
    set_op(0, 4'h3, 4'h5);
    force_zero    = 1'b1;
    bus.req_valid = 4'b0001;
    tick;
    bus.req_valid = 4'h0;
    check("chk_issue_cycle", 32'(chk_err), 32'h0);
    tick;
    check("chk_set", 32'(chk_err), 32'h1);
    force_zero = 1'b0;
    tick;
    tick;
    check("chk_sticky", 32'(chk_err), 32'h1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("chk_cleared", 32'(chk_err), 32'h0);
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        set_op(0, 4'(a), 4'(b));
        bus.req_valid = 4'b0001;
        tick;
        bus.req_valid = 4'h0;
        tick;
        check("sweep_res_data", 32'(bus.res_data), 32'(a * b));
        tick;
      end
    end
    check("chk_sweep_clean", 32'(chk_err), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
